// File: rtl/nec_cmd_scheduler_if.sv
// Signal bundle between the NEC receiver / firmware and nec_cmd_scheduler.
// Optional: NEC_CMD_STATS_EN adds the statistics counter outputs.
interface nec_cmd_scheduler_if #(
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             ir_valid_i;
  logic [7:0]       ir_addr_i;
  logic [7:0]       ir_data_i;
  logic             ir_repeat_i;
  logic             cfg_chk_i;
  logic [7:0]       cfg_addr_i;
  logic             sw_valid_i;
  logic [7:0]       sw_cmd_i;
  logic             sw_ready_o;
  logic             cmd_valid_o;
  logic [7:0]       cmd_data_o;
  logic             cmd_src_o;
  logic             cmd_ready_i;
  logic             drop_o;
  logic [LVL_W-1:0] fifo_level_o;
`ifdef NEC_CMD_STATS_EN
  logic [7:0]       stat_acc_o;
  logic [7:0]       stat_drop_o;

  modport slave (
    input  ir_valid_i, ir_addr_i, ir_data_i, ir_repeat_i, cfg_chk_i, cfg_addr_i,
    input  sw_valid_i, sw_cmd_i, cmd_ready_i,
    output sw_ready_o, cmd_valid_o, cmd_data_o, cmd_src_o, drop_o, fifo_level_o,
    output stat_acc_o, stat_drop_o
  );

  modport master (
    output ir_valid_i, ir_addr_i, ir_data_i, ir_repeat_i, cfg_chk_i, cfg_addr_i,
    output sw_valid_i, sw_cmd_i, cmd_ready_i,
    input  sw_ready_o, cmd_valid_o, cmd_data_o, cmd_src_o, drop_o, fifo_level_o,
    input  stat_acc_o, stat_drop_o
  );
`else
  modport slave (
    input  ir_valid_i, ir_addr_i, ir_data_i, ir_repeat_i, cfg_chk_i, cfg_addr_i,
    input  sw_valid_i, sw_cmd_i, cmd_ready_i,
    output sw_ready_o, cmd_valid_o, cmd_data_o, cmd_src_o, drop_o, fifo_level_o
  );

  modport master (
    output ir_valid_i, ir_addr_i, ir_data_i, ir_repeat_i, cfg_chk_i, cfg_addr_i,
    output sw_valid_i, sw_cmd_i, cmd_ready_i,
    input  sw_ready_o, cmd_valid_o, cmd_data_o, cmd_src_o, drop_o, fifo_level_o
  );
`endif
endinterface

// File: rtl/nec_cmd_scheduler.sv
// Filters/expands decoded NEC frames, buffers them and round-robins them with firmware commands.
// Optional: NEC_CMD_STATS_EN adds saturating accepted/dropped command counters.
module nec_cmd_scheduler #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned REPEAT_HOLD = 4096
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  nec_cmd_scheduler_if.slave bus
);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned HOLD_W = $clog2(REPEAT_HOLD + 1);

  typedef enum logic {PRI_IR = 1'b0, PRI_SW = 1'b1} pri_e;

  pri_e              pri_q, pri_d;
  logic              grant_ir, grant_sw;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q;
  logic              drop_q;

  logic              last_vld_q;
  logic [7:0]        last_cmd_q;
  logic [HOLD_W-1:0] hold_q;

  logic              cmd_valid_q, cmd_src_q;
  logic [7:0]        cmd_data_q;

  logic              addr_ok, accept, repeat_ok, push, pop, load;
  logic              fifo_empty, fifo_full, do_write, drop_set;
  logic [7:0]        push_data;

  // A frame in the same cycle as a repeat always wins, even if its address is filtered out.
  assign addr_ok    = !bus.cfg_chk_i || (bus.ir_addr_i == bus.cfg_addr_i);
  assign accept     = bus.ir_valid_i && addr_ok;
  assign repeat_ok  = bus.ir_repeat_i && !bus.ir_valid_i && last_vld_q &&
                      (hold_q < HOLD_W'(REPEAT_HOLD));
  assign push       = accept || repeat_ok;
  assign push_data  = accept ? bus.ir_data_i : last_cmd_q;

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
  assign load       = !cmd_valid_q || bus.cmd_ready_i;
  assign pop        = grant_ir;
  assign do_write   = push && (!fifo_full || pop);
  assign drop_set   = push && fifo_full && !pop;

  // Arbiter priority register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) pri_q <= PRI_IR;
    else          pri_q <= pri_d;
  end

  // Priority flips to the other source after every grant
  always_comb begin
    pri_d = pri_q;
    if (grant_ir)      pri_d = PRI_SW;
    else if (grant_sw) pri_d = PRI_IR;
  end

  // Grants are only issued when the output register can take a new command
  always_comb begin
    grant_ir = 1'b0;
    grant_sw = 1'b0;
    if (!wb_rst_i && load) begin
      if (!fifo_empty && (pri_q == PRI_IR || !bus.sw_valid_i)) grant_ir = 1'b1;
      else if (bus.sw_valid_i)                                 grant_sw = 1'b1;
    end
  end

  assign bus.sw_ready_o = grant_sw;

  // FIFO storage, no reset needed
  always_ff @(posedge wb_clk_i) begin
    if (do_write) mem_q[wr_ptr_q] <= push_data;
  end

  // FIFO pointers wrap naturally since FIFO_DEPTH is a power of two
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      if (do_write) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)      rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_write && !pop)      level_q <= level_q + LVL_W'(1);
      else if (pop && !do_write) level_q <= level_q - LVL_W'(1);
      drop_q <= drop_set;
    end
  end

  // Last command and repeat window; the counter parks at REPEAT_HOLD once the window closes
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      last_vld_q <= 1'b0;
      last_cmd_q <= '0;
      hold_q     <= '0;
    end else if (push) begin
      last_vld_q <= 1'b1;
      hold_q     <= '0;
      if (accept) last_cmd_q <= bus.ir_data_i;
    end else if (last_vld_q) begin
      hold_q <= hold_q + HOLD_W'(1);
      if (hold_q == HOLD_W'(REPEAT_HOLD - 1)) last_vld_q <= 1'b0;
    end
  end

  // Output register, held while stalled
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cmd_valid_q <= 1'b0;
      cmd_data_q  <= '0;
      cmd_src_q   <= 1'b0;
    end else if (load) begin
      cmd_valid_q <= grant_ir || grant_sw;
      if (grant_ir) begin
        cmd_data_q <= mem_q[rd_ptr_q];
        cmd_src_q  <= 1'b0;
      end else if (grant_sw) begin
        cmd_data_q <= bus.sw_cmd_i;
        cmd_src_q  <= 1'b1;
      end
    end
  end

  assign bus.cmd_valid_o  = cmd_valid_q;
  assign bus.cmd_data_o   = cmd_data_q;
  assign bus.cmd_src_o    = cmd_src_q;
  assign bus.drop_o       = drop_q;
  assign bus.fifo_level_o = level_q;

`ifdef NEC_CMD_STATS_EN
  logic [7:0] stat_acc_q, stat_drop_q;

  // Saturating event counters
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      stat_acc_q  <= '0;
      stat_drop_q <= '0;
    end else begin
      if (push && stat_acc_q != 8'hFF)      stat_acc_q  <= stat_acc_q + 8'd1;
      if (drop_set && stat_drop_q != 8'hFF) stat_drop_q <= stat_drop_q + 8'd1;
    end
  end

  assign bus.stat_acc_o  = stat_acc_q;
  assign bus.stat_drop_o = stat_drop_q;
`endif
endmodule
